vga_sync_gen: RTL and testbench

Pixel-timing generator for the 40 MHz pixel-clock domain. Runs horizontal and vertical counters for 800x600@60 Hz SVGA timing and drives registered hsync, vsync, data-enable and pixel coordinates. Feeds the rgb/pattern stage that drives the pin-level colour expansion. Also issues a one-cycle-early pixel request so a downstream source with 1-cycle read latency lines up with de.

---
 rtl/vga_sync_gen.sv | 94 +++++++++
 tb/tb_vga_sync_gen.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// SVGA pixel-timing generator: free-running h/v counters with a combinational
// one-clock-early pixel request and registered sync/enable/coordinate outputs.
module vga_sync_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int CW       = 11
) (
  input  logic          clk,
  input  logic          rst,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic          req,
  output logic [CW-1:0] req_x,
  output logic [CW-1:0] req_y,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_ACT_END  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] H_SYNC_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_SYNC_END = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_ACT_END  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] V_SYNC_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_SYNC_END = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);

  logic [CW-1:0] h_cnt;
  logic [CW-1:0] v_cnt;
  logic          h_wrap;
  logic          v_wrap;
  logic          active;
  logic          h_sync_on;
  logic          v_sync_on;

  assign h_wrap = (h_cnt == H_LAST);
  assign v_wrap = (v_cnt == V_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      if (h_wrap) begin
        h_cnt <= '0;
        v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  // v_cnt only moves at the line wrap, so vsync edges land on line boundaries.
  assign active    = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
  assign h_sync_on = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
  assign v_sync_on = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);

  assign req   = active;
  assign req_x = active ? h_cnt : '0;
  assign req_y = active ? v_cnt : '0;

  // Outputs lag the request decode by one clock to match a 1-cycle read source.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      de          <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= h_sync_on ? HS_POL : ~HS_POL;
      vsync       <= v_sync_on ? VS_POL : ~VS_POL;
      de          <= active;
      pix_x       <= req_x;
      pix_y       <= req_y;
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: three instances (default timing, reduced timing,
// reduced timing with inverted sync polarity) checked each cycle against a model.
`timescale 1ns/100ps
module tb_vga_sync_gen;

  typedef struct packed {
    logic        hsync;
    logic        vsync;
    logic        de;
    logic        fs;
    logic        req;
    logic [10:0] px;
    logic [10:0] py;
    logic [10:0] rx;
    logic [10:0] ry;
  } sig_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   k;
  int   checks = 0;
  int   failures = 0;
  bit   done = 1'b0;

  always #5 clk = ~clk;

  // Edges seen since the last reset release: the whole timing is a function of it.
  always @(posedge clk or posedge rst) begin
    if (rst) k <= 0;
    else     k <= k + 1;
  end

  logic        d_hs, d_vs, d_de, d_rq, d_fs;
  logic [10:0] d_px, d_py, d_rx, d_ry;
  logic        s_hs, s_vs, s_de, s_rq, s_fs;
  logic [10:0] s_px, s_py, s_rx, s_ry;
  logic        i_hs, i_vs, i_de, i_rq, i_fs;
  logic [10:0] i_px, i_py, i_rx, i_ry;

  vga_sync_gen u_def (
    .clk(clk), .rst(rst), .hsync(d_hs), .vsync(d_vs), .de(d_de),
    .pix_x(d_px), .pix_y(d_py), .req(d_rq), .req_x(d_rx), .req_y(d_ry),
    .frame_start(d_fs)
  );

  vga_sync_gen #(
    .H_ACTIVE(16), .H_FP(3), .H_SYNC(5), .H_BP(4),
    .V_ACTIVE(10), .V_FP(1), .V_SYNC(2), .V_BP(3)
  ) u_sml (
    .clk(clk), .rst(rst), .hsync(s_hs), .vsync(s_vs), .de(s_de),
    .pix_x(s_px), .pix_y(s_py), .req(s_rq), .req_x(s_rx), .req_y(s_ry),
    .frame_start(s_fs)
  );

  vga_sync_gen #(
    .H_ACTIVE(16), .H_FP(3), .H_SYNC(5), .H_BP(4),
    .V_ACTIVE(10), .V_FP(1), .V_SYNC(2), .V_BP(3),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) u_inv (
    .clk(clk), .rst(rst), .hsync(i_hs), .vsync(i_vs), .de(i_de),
    .pix_x(i_px), .pix_y(i_py), .req(i_rq), .req_x(i_rx), .req_y(i_ry),
    .frame_start(i_fs)
  );

  sig_t act_d, act_s, act_i;
  assign act_d = '{d_hs, d_vs, d_de, d_fs, d_rq, d_px, d_py, d_rx, d_ry};
  assign act_s = '{s_hs, s_vs, s_de, s_fs, s_rq, s_px, s_py, s_rx, s_ry};
  assign act_i = '{i_hs, i_vs, i_de, i_fs, i_rq, i_px, i_py, i_rx, i_ry};

  // Position n counts pixels from the top-left of frame 0; the request reflects
  // position n, the registered outputs position n-1 (or reset values for n=0).
  function automatic sig_t model(int n, int ha, int hfp, int hs, int hbp,
                                 int va, int vfp, int vs, int vbp, bit hp, bit vp);
    int   ht = ha + hfp + hs + hbp;
    int   vt = va + vfp + vs + vbp;
    int   h, v;
    sig_t s;
    s = '0;
    h = n % ht;
    v = (n / ht) % vt;
    if (h < ha && v < va) begin
      s.req = 1'b1;
      s.rx  = 11'(h);
      s.ry  = 11'(v);
    end
    if (n == 0) begin
      s.hsync = ~hp;
      s.vsync = ~vp;
    end else begin
      h = (n - 1) % ht;
      v = ((n - 1) / ht) % vt;
      s.hsync = (h >= ha + hfp && h < ha + hfp + hs) ? hp : ~hp;
      s.vsync = (v >= va + vfp && v < va + vfp + vs) ? vp : ~vp;
      if (h < ha && v < va) begin
        s.de = 1'b1;
        s.px = 11'(h);
        s.py = 11'(v);
      end
      s.fs = ((n - 1) % (ht * vt)) == 0;
    end
    return s;
  endfunction

  task automatic chk(string name, sig_t act, sig_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s k=%0d got=%h want=%h", name, k, act, exp);
    end
  endtask

  task automatic lit(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s k=%0d got=%0d want=%0d", name, k, act, exp);
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, "_def"}, act_d, model(k, 800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1));
    chk({tag, "_sml"}, act_s, model(k, 16, 3, 5, 4, 10, 1, 2, 3, 1'b1, 1'b1));
    chk({tag, "_inv"}, act_i, model(k, 16, 3, 5, 4, 10, 1, 2, 3, 1'b0, 1'b0));
  endtask

  always @(negedge clk) begin
    if (!done) check_all("cycle");
  end

  int fs_cnt, de_cnt_s, de_cnt_i, hs_cnt_d;

  initial begin
    int d, run, hold;
    fs_cnt = 0; de_cnt_s = 0; de_cnt_i = 0; hs_cnt_d = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;

    while (k < 2837) begin
      @(negedge clk);
      if (k >= 1 && k <= 1344 && s_fs) fs_cnt++;
      if (k >= 1 && k <= 448) begin
        if (s_de) de_cnt_s++;
        if (i_de) de_cnt_i++;
      end
      if (k >= 1 && k <= 1056 && d_hs) hs_cnt_d++;
      case (k)
        1: begin
          lit("first_de", d_de, 1);
          lit("first_fs", d_fs, 1);
          lit("first_pix", {d_px, d_py}, 0);
          lit("first_hs", d_hs, 0);
          lit("req_lead_x", d_rx, 1);
          lit("inv_hs_idle", i_hs, 1);
          lit("inv_vs_idle", i_vs, 1);
        end
        19:   lit("sml_hs_pre", s_hs, 0);
        20:   lit("sml_hs_on", s_hs, 1);
        308:  lit("sml_vs_pre", s_vs, 0);
        309: begin
          lit("sml_vs_on", s_vs, 1);
          lit("inv_vs_on", i_vs, 0);
        end
        449:  lit("sml_fs_frame1", s_fs, 1);
        800: begin
          lit("last_px_x", d_px, 799);
          lit("last_px_de", d_de, 1);
        end
        801:  lit("after_last_de", d_de, 0);
        840:  lit("hs_pre", d_hs, 0);
        841:  lit("hs_assert", d_hs, 1);
        968:  lit("hs_last", d_hs, 1);
        969:  lit("hs_deassert", d_hs, 0);
        1057: begin
          lit("line1_pix", {d_px, d_py}, {11'd0, 11'd1});
          lit("line1_de", d_de, 1);
          lit("line1_fs", d_fs, 0);
        end
        default: ;
      endcase
    end
    lit("sml_fs_3frames", fs_cnt, 3);
    lit("sml_de_per_frame", de_cnt_s, 160);
    lit("inv_de_per_frame", de_cnt_i, 160);
    lit("def_hs_width", hs_cnt_d, 128);

    // Mid-line reset on the reduced-timing instance at pixel (8,5).
    lit("pre_rst_pix", {s_px, s_py}, {11'd8, 11'd5});
    #2 rst = 1'b1;
    #0.5;
    lit("rst_de", s_de, 0);
    lit("rst_pix", {s_px, s_py}, 0);
    lit("rst_fs", s_fs, 0);
    lit("rst_req", s_rq, 1);
    lit("rst_inv_hs", i_hs, 1);
    check_all("rst_mid");
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    lit("rel_fs", s_fs, 1);
    lit("rel_pix", {s_px, s_py, 10'd0, s_de}, {22'd0, 10'd0, 1'b1});

    for (int i = 0; i < 20; i++) begin
      run = $urandom_range(10, 1000);
      repeat (run) @(negedge clk);
      d = $urandom_range(1, 8);
      if (d == 5) d = 6;
      #(d) rst = 1'b1;
      #0.5 check_all("async_rst");
      hold = $urandom_range(1, 6);
      repeat (hold) @(posedge clk);
      @(negedge clk);
      #2 rst = 1'b0;
    end

    repeat (50) @(negedge clk);
    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
